// File: rtl/fpu_pkg.sv
// Shared FP constants and the result-queue entry type used by the
// multiplier result path.
package fpu_pkg;

  localparam int FLOAT_W       = 32;
  localparam int EXP_LSB       = 23;
  localparam int MANT_W        = 23;
  localparam int DEFAULT_TAG_W = 5;

  typedef struct packed {
    logic [FLOAT_W-1:0]       data;
    logic [DEFAULT_TAG_W-1:0] tag;
    logic                     zero;
  } fpu_result_t;

endpackage

// File: rtl/fpu_result_queue.sv
// FIFO of multiplier results (value, destination tag, zero flag) feeding the
// FP register-file write port over a valid/ready handshake.
module fpu_result_queue
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = DEFAULT_TAG_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FLOAT_W-1:0]       in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FLOAT_W-1:0]       out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; ready/valid here depend only on the registered count.

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fpu_result_queue: DEPTH must be a power of two >= 2");
  end
  if (TAG_W != DEFAULT_TAG_W) begin : g_bad_tag
    $error("fpu_result_queue: TAG_W must match fpu_pkg::DEFAULT_TAG_W");
  end

  fpu_result_t        r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_push;
  logic               w_pop;
  fpu_result_t        w_wr_entry;
  fpu_result_t        w_head;

  assign in_ready  = (r_count < CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  // Flush overrides any transfer presented in the same cycle.
  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  always_comb begin
    w_wr_entry      = '0;
    w_wr_entry.data = in_data;
    w_wr_entry.tag  = in_tag;
    // Underflow is flushed to signed zero upstream, so ignore the sign bit.
    w_wr_entry.zero = (in_data[FLOAT_W-2:0] == '0);
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign out_data = w_head.data;
  assign out_tag  = w_head.tag;
  assign out_zero = w_head.zero;

  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (!rstn) !(in_valid && !in_ready)
  ) else $warning("fpu_result_queue: in_valid while full, result dropped");

endmodule

// File: tb/tb_fpu_result_queue.sv
// Directed bench for fpu_result_queue: drivers enqueue expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_fpu_result_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int EW    = 32 + TAG_W + 1;

  logic              clk;
  logic              rstn;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_zero;
  logic [2:0]        count;

  logic [EW-1:0]     exp_q[$];
  int                total;
  int                bad;

  fpu_result_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_zero  (out_zero),
    .count     (count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one result for a cycle; exp_accept is the hand-derived in_ready.
  task automatic push_item(input logic [31:0] data, input logic [TAG_W-1:0] tag,
                           input logic exp_zero, input logic exp_accept);
    in_valid = 1'b1;
    in_data  = data;
    in_tag   = tag;
    @(negedge clk);
    chk("in_ready_at_push", {31'b0, in_ready}, {31'b0, exp_accept});
    if (exp_accept) exp_q.push_back({data, tag, exp_zero});
    next_cycle();
    in_valid = 1'b0;
  endtask

  task automatic pop_cycles(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) next_cycle();
    out_ready = 1'b0;
  endtask

  task automatic check_state(input string tag_name, input logic [2:0] exp_count);
    @(negedge clk);
    chk({tag_name, "_count"}, {29'b0, count}, {29'b0, exp_count});
    chk({tag_name, "_out_valid"}, {31'b0, out_valid}, {31'b0, (exp_count != 0)});
    chk({tag_name, "_in_ready"}, {31'b0, in_ready}, {31'b0, (exp_count < 3'd4)});
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rstn && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got tag %0d expected none", out_tag);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("pop_data", out_data, e[EW-1 -: 32]);
        chk("pop_tag", {27'b0, out_tag}, {27'b0, e[TAG_W:1]});
        chk("pop_zero", {31'b0, out_zero}, {31'b0, e[0]});
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    rstn = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_tag = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    check_state("reset_idle", 3'd0);
    next_cycle();

    // Single pass
    push_item(32'h40C00000, 5'd3, 1'b0, 1'b1);
    check_state("single_held", 3'd1);
    pop_cycles(1);
    check_state("single_done", 3'd0);
    next_cycle();

    // Fill to full with a rejected fifth push
    push_item(32'h3F800000, 5'd1, 1'b0, 1'b1);
    push_item(32'h40000000, 5'd2, 1'b0, 1'b1);
    push_item(32'h40400000, 5'd3, 1'b0, 1'b1);
    push_item(32'h40800000, 5'd4, 1'b0, 1'b1);
    push_item(32'h40A00000, 5'd5, 1'b0, 1'b0);
    check_state("full", 3'd4);
    next_cycle();
    pop_cycles(2);
    push_item(32'h40C00000, 5'd6, 1'b0, 1'b1);
    push_item(32'h40E00000, 5'd7, 1'b0, 1'b1);
    check_state("refull", 3'd4);
    next_cycle();

    // in_valid and out_ready together while full: only the pop happens
    in_valid  = 1'b1;
    in_data   = 32'h41000000;
    in_tag    = 5'd8;
    out_ready = 1'b1;
    check_state("full_both", 3'd4);
    next_cycle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_state("after_full_pop", 3'd3);
    next_cycle();
    pop_cycles(3);
    check_state("drained", 3'd0);
    chk("queue_empty_after_drain", exp_q.size(), 32'd0);
    next_cycle();

    // Zero flag for -0, +0 and smallest normal
    push_item(32'h80000000, 5'd9,  1'b1, 1'b1);
    push_item(32'h00000000, 5'd10, 1'b1, 1'b1);
    push_item(32'h00800000, 5'd11, 1'b0, 1'b1);
    pop_cycles(3);
    check_state("zero_drained", 3'd0);
    next_cycle();

    // Flush beats a simultaneous push
    push_item(32'h3F800000, 5'd12, 1'b0, 1'b1);
    push_item(32'h40000000, 5'd13, 1'b0, 1'b1);
    push_item(32'h40400000, 5'd14, 1'b0, 1'b1);
    check_state("pre_flush", 3'd3);
    next_cycle();
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h40800000;
    in_tag    = 5'd15;
    out_ready = 1'b1;
    next_cycle();
    exp_q.delete();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_state("post_flush", 3'd0);
    next_cycle();

    // Asynchronous reset between edges
    push_item(32'h40A00000, 5'd16, 1'b0, 1'b1);
    push_item(32'h40C00000, 5'd17, 1'b0, 1'b1);
    check_state("pre_reset", 3'd2);
    #2;
    rstn = 1'b0;
    exp_q.delete();
    #1;
    chk("reset_async_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_async_count", {29'b0, count}, 32'd0);
    next_cycle();
    rstn = 1'b1;
    check_state("post_reset", 3'd0);
    next_cycle();

    // Operation resumes after reset
    push_item(32'hBF800000, 5'd18, 1'b0, 1'b1);
    pop_cycles(1);
    check_state("final", 3'd0);
    chk("queue_empty_final", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
